// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for producers and consumers of the
// 32x32 register file write port.
//   REG_AW   - register address width
//   REG_DW   - register data width
//   REG_ZERO - address of the hard-wired zero register
//   wb_req_t - one register-write request {waddr, wdata}
package regfile_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_AW-1:0] waddr;
        logic [REG_DW-1:0] wdata;
    } wb_req_t;

endpackage : regfile_pkg

// File: rtl/wb_fifo_ram.sv
// wb_fifo_ram: DEPTH-entry storage for queued register writes.
// Single write port addressed by the queue tail pointer; every entry is
// presented in parallel so the owner can do head read-out and address
// lookup without extra read ports.
//   i_clk, i_rst_n   - clock, async active-low reset (clears all entries)
//   i_we             - write strobe
//   i_wptr           - entry index to write
//   i_waddr/i_wdata  - request being stored
//   o_waddr_all      - destination register of every entry
//   o_wdata_all      - data of every entry
module wb_fifo_ram
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_we,
    input  logic [PW-1:0]              i_wptr,
    input  logic [AW-1:0]              i_waddr,
    input  logic [DW-1:0]              i_wdata,
    output logic [DEPTH-1:0][AW-1:0]   o_waddr_all,
    output logic [DEPTH-1:0][DW-1:0]   o_wdata_all
);

    logic [DEPTH-1:0][AW-1:0] r_waddr;
    logic [DEPTH-1:0][DW-1:0] r_wdata;

    // Entry storage; cleared on reset so a discarded queue leaves no stale data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (i_we) begin
            r_waddr[i_wptr] <= i_waddr;
            r_wdata[i_wptr] <= i_wdata;
        end
    end

    assign o_waddr_all = r_waddr;
    assign o_wdata_all = r_wdata;

endmodule : wb_fifo_ram

// File: rtl/regfile_wb_writer.sv
// regfile_wb_writer: write-back side driver for the register file write port.
// Two producers (s0 = ALU, s1 = load/mul-div) hand in writes through
// valid/ready; s0 has fixed priority. Accepted writes go into an in-order
// queue which retires one entry per cycle onto rf_we/rf_waddr/rf_wdata.
// Two combinational lookup ports report the youngest pending write to a
// register so decode can forward values not yet in the register file.
//   clk, rst                 - clock, async active-low reset
//   s0_* / s1_*              - producer handshakes and requests
//   rf_we/rf_waddr/rf_wdata  - register file write port (head of queue)
//   q_raddr1/2 -> q_hit1/2, q_data1/2 - pending-write lookup
//   busy                     - queue non-empty
module regfile_wb_writer
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s0_valid,
    output logic          s0_ready,
    input  logic [AW-1:0] s0_waddr,
    input  logic [DW-1:0] s0_wdata,
    input  logic          s1_valid,
    output logic          s1_ready,
    input  logic [AW-1:0] s1_waddr,
    input  logic [DW-1:0] s1_wdata,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    input  logic [AW-1:0] q_raddr1,
    input  logic [AW-1:0] q_raddr2,
    output logic          q_hit1,
    output logic          q_hit2,
    output logic [DW-1:0] q_data1,
    output logic [DW-1:0] q_data2,
    output logic          busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic                     w_not_full;
    logic                     w_nonempty;
    logic                     w_acc0;
    logic                     w_acc1;
    logic [AW-1:0]            w_req_waddr;
    logic [DW-1:0]            w_req_wdata;
    logic                     w_push;
    logic                     w_pop;
    logic [DEPTH-1:0][AW-1:0] w_waddr_all;
    logic [DEPTH-1:0][DW-1:0] w_wdata_all;
    logic [DW:0]              w_look1;
    logic [DW:0]              w_look2;

    // Youngest-match search over valid entries: walk oldest to youngest so
    // the last match seen (nearest the tail) wins. Register 0 never hits.
    function automatic logic [DW:0] f_lookup(
        input logic [AW-1:0]            raddr,
        input logic [DEPTH-1:0][AW-1:0] addrs,
        input logic [DEPTH-1:0][DW-1:0] datas,
        input logic [PW-1:0]            head,
        input logic [CW-1:0]            count
    );
        logic          hit;
        logic [DW-1:0] data;
        logic [PW-1:0] idx;
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (raddr != '0) && (addrs[idx] == raddr)) begin
                hit  = 1'b1;
                data = datas[idx];
            end
        end
        return {hit, data};
    endfunction

    // Handshake, arbitration and push/pop decisions.
    always_comb begin
        w_not_full = (r_count < CW'(DEPTH));
        w_nonempty = (r_count != '0);
        s0_ready   = rst && w_not_full;
        s1_ready   = rst && w_not_full && !s0_valid;
        w_acc0     = s0_valid && s0_ready;
        w_acc1     = s1_valid && s1_ready;
        if (w_acc0) begin
            w_req_waddr = s0_waddr;
            w_req_wdata = s0_wdata;
        end else begin
            w_req_waddr = s1_waddr;
            w_req_wdata = s1_wdata;
        end
        // Writes to register 0 complete the handshake but are dropped here.
        w_push = (w_acc0 || w_acc1) && (w_req_waddr != '0);
        w_pop  = w_nonempty;
    end

    // Queue pointers and occupancy; simultaneous push and pop keep count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end else begin
                r_tail <= r_tail;
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end else begin
                r_head <= r_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    wb_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .PW    (PW)
    ) u_ram (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_we        (w_push),
        .i_wptr      (r_tail),
        .i_waddr     (w_req_waddr),
        .i_wdata     (w_req_wdata),
        .o_waddr_all (w_waddr_all),
        .o_wdata_all (w_wdata_all)
    );

    // Register file port driven straight from the head entry; zero when empty.
    always_comb begin
        rf_we = w_nonempty;
        busy  = w_nonempty;
        if (w_nonempty) begin
            rf_waddr = w_waddr_all[r_head];
            rf_wdata = w_wdata_all[r_head];
        end else begin
            rf_waddr = '0;
            rf_wdata = '0;
        end
    end

    // Pending-write lookup for both decode read ports.
    always_comb begin
        w_look1 = f_lookup(q_raddr1, w_waddr_all, w_wdata_all, r_head, r_count);
        w_look2 = f_lookup(q_raddr2, w_waddr_all, w_wdata_all, r_head, r_count);
        q_hit1  = w_look1[DW];
        q_data1 = w_look1[DW-1:0];
        q_hit2  = w_look2[DW];
        q_data2 = w_look2[DW-1:0];
    end

endmodule : regfile_wb_writer
